// File: rtl/seg7_scan_scheduler.sv
// Four-digit common-anode 7-segment scan scheduler with an internal refresh prescaler,
// anti-ghost blanking between digits and a frame-synchronous double buffer.
module seg7_scan_scheduler #(
  parameter int unsigned DIV_WIDTH    = 17,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        in_clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_blank,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned BW        = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned IDX_W     = 2;
  localparam logic [SEG_W-1:0] SEG_DARK = 7'h7F;
  localparam logic [3:0]       AN_DARK  = 4'b1111;
  localparam logic [BW-1:0]    BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [BW-1:0]          blank_cnt;
  logic [DIV_WIDTH-1:0]   presc;
  logic [15:0]            active_val;
  logic [3:0]             active_dp;
  logic [15:0]            pend_val;
  logic [3:0]             pend_dp;

  logic [NIB_W-1:0]       cur_nib_c;
  logic [3:0]             sup_c;
  logic [SEG_W-1:0]       drive_seg_c;
  logic [3:0]             drive_an_c;
  logic                   drive_dp_c;
  logic                   last_digit_c;

  // Active-low hex decode, bit order g..a.
  function automatic logic [SEG_W-1:0] hex_decode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Drive pattern for the current digit; the active buffer is stable for the whole frame.
  always_comb begin
    cur_nib_c    = '0;
    sup_c        = '0;
    drive_seg_c  = SEG_DARK;
    drive_an_c   = AN_DARK;
    drive_dp_c   = 1'b1;
    last_digit_c = 1'b0;

    case (idx)
      2'd0:    cur_nib_c = active_val[3:0];
      2'd1:    cur_nib_c = active_val[7:4];
      2'd2:    cur_nib_c = active_val[11:8];
      default: cur_nib_c = active_val[15:12];
    endcase

    // A digit is suppressed only if it and every digit to its left are zero.
    sup_c[3] = lz_blank && (active_val[15:12] == 4'h0);
    sup_c[2] = sup_c[3] && (active_val[11:8] == 4'h0);
    sup_c[1] = sup_c[2] && (active_val[7:4] == 4'h0);
    sup_c[0] = 1'b0;

    drive_seg_c  = sup_c[idx] ? SEG_DARK : hex_decode(cur_nib_c);
    drive_an_c   = ~(4'b0001 << idx);
    drive_dp_c   = ~active_dp[idx];
    last_digit_c = (idx == 2'd3);
  end

  // Scan FSM with registered outputs and double-buffered display value.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BLANK;
      idx        <= '0;
      blank_cnt  <= '0;
      presc      <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      seg_n      <= SEG_DARK;
      dp_n       <= 1'b1;
      an_n       <= AN_DARK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seg_n      <= SEG_DARK;
      dp_n       <= 1'b1;
      an_n       <= AN_DARK;

      if (!enable) begin
        state     <= ST_BLANK;
        blank_cnt <= '0;
        presc     <= '0;
      end else begin
        case (state)
          ST_BLANK: begin
            if (blank_cnt == BLANK_LAST) begin
              state <= ST_DRIVE;
              presc <= '0;
              seg_n <= drive_seg_c;
              dp_n  <= drive_dp_c;
              an_n  <= drive_an_c;
            end else begin
              blank_cnt <= blank_cnt + BW'(1);
            end
          end
          ST_DRIVE: begin
            if (&presc) begin
              state     <= ST_BLANK;
              idx       <= idx + IDX_W'(1);
              blank_cnt <= '0;
              // Frame wrap: the only point where the active buffer may change.
              if (last_digit_c) begin
                frame_done <= 1'b1;
                if (pending) begin
                  active_val <= pend_val;
                  active_dp  <= pend_dp;
                  pending    <= 1'b0;
                end
              end
            end else begin
              presc <= presc + DIV_WIDTH'(1);
              seg_n <= drive_seg_c;
              dp_n  <= drive_dp_c;
              an_n  <= drive_an_c;
            end
          end
          default: begin
            state     <= ST_BLANK;
            blank_cnt <= '0;
            presc     <= '0;
          end
        endcase
      end

      // A load on the commit edge lands after the commit and keeps pending set.
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Bench for seg7_scan_scheduler: directed scenarios plus random traffic against a
// slot-position reference model of the scan timing and the double buffer.
module tb_seg7_scan_scheduler;

  localparam int unsigned DW = 4;
  localparam int unsigned BC = 2;
  localparam int L  = BC + (1 << DW);

  logic        in_clk = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_blank;
  logic        enable;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;
  logic        pending;

  seg7_scan_scheduler #(.DIV_WIDTH(DW), .BLANK_CYCLES(BC)) dut (
    .in_clk(in_clk), .reset_n(reset_n), .value(value), .dp_in(dp_in),
    .load(load), .lz_blank(lz_blank), .enable(enable), .seg_n(seg_n),
    .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done), .pending(pending)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int first_fd = 0;

  // Reference model: position within the current digit slot (blank gap + drive time).
  int          m_pos, m_idx;
  logic [15:0] m_act, m_pv;
  logic [3:0]  m_adp, m_pdp;
  logic        m_pend, m_fd;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp, cyc_n, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_idx = 0; m_act = '0; m_pv = '0; m_adp = '0; m_pdp = '0;
    m_pend = 1'b0; m_fd = 1'b0; e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
  endtask

  task automatic model_step();
    logic [15:0] upper;
    m_fd = 1'b0;
    if (!enable) begin
      m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == L) begin
        m_pos = 0;
        m_idx = (m_idx + 1) % 4;
        if (m_idx == 0) begin
          m_fd = 1'b1;
          if (m_pend) begin
            m_act = m_pv; m_adp = m_pdp; m_pend = 1'b0;
          end
        end
      end
    end
    if (load) begin
      m_pv = value; m_pdp = dp_in; m_pend = 1'b1;
    end
    if (!enable || m_pos < BC) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      upper = m_act >> (4 * m_idx);
      e_an  = 4'(~(4'd1 << m_idx));
      e_seg = (lz_blank && m_idx != 0 && upper == 16'h0) ? 7'h7F : hex7(upper[3:0]);
      e_dp  = ~m_adp[m_idx];
    end
  endtask

  task automatic compare_all();
    check("an_n", 32'(an_n), 32'(e_an));
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("pending", 32'(pending), 32'(m_pend));
    check("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
  endtask

  // One clock: model follows the inputs seen at the edge, DUT sampled 1 time unit later.
  task automatic cyc();
    @(posedge in_clk);
    model_step();
    cyc_n++;
    #1;
    compare_all();
    @(negedge in_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until(input int ti, input int tp);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_idx == ti && m_pos == tp) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check("wait_bound", 32'(ok), 32'd1);
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int dis;
    reset_n = 1'b0; value = '0; dp_in = '0; load = 1'b0; lz_blank = 1'b0; enable = 1'b0;
    model_reset();
    repeat (3) @(negedge in_clk);
    compare_all();
    reset_n = 1'b1;
    enable  = 1'b1;

    // Frame 1 shows zeros; frame 2 shows 12AF with dp on digit 2.
    load_once(16'h12AF, 4'b0100);
    for (int i = 0; i < 160; i++) begin
      cyc();
      if (frame_done && first_fd == 0) first_fd = cyc_n;
      if (cyc_n == 74)         check("f2_d0_seg", 32'(seg_n), 32'h0E);
      if (cyc_n == 74 + L)     check("f2_d1_seg", 32'(seg_n), 32'h08);
      if (cyc_n == 74 + 2 * L) check("f2_d2_dp", 32'(dp_n), 32'd0);
      if (cyc_n == 74 + 3 * L) check("f2_d3_an", 32'(an_n), 32'b0111);
    end
    check("first_frame_done", 32'(first_fd), 32'd72);

    // Leading-zero suppression.
    lz_blank = 1'b1;
    load_once(16'h0030, 4'b0000);
    run(170);
    load_once(16'h0000, 4'b1010);
    run(170);
    lz_blank = 1'b0;

    // Mid-frame loads: last write wins at the wrap.
    run_until(1, BC + 3);
    load_once(16'h1111, 4'h0);
    run_until(2, BC + 3);
    load_once(16'h2222, 4'h0);
    run(160);

    // Load coincident with the commit edge while nothing is pending.
    run_until(3, L - 1);
    load_once(16'hAAAA, 4'h0);
    check("cedge_pending", 32'(pending), 32'd1);
    run(160);

    // Disable during digit 2, then resume.
    run_until(2, BC + 5);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(60);

    // Random traffic.
    dis = 0;
    for (int i = 0; i < 2500; i++) begin
      load  = ($urandom_range(0, 49) == 0);
      value = 16'(32'($urandom) >> (4 * $urandom_range(0, 4)));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      if (dis > 0) begin
        dis--;
        if (dis == 0) enable = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        dis = $urandom_range(1, 30);
      end
      cyc();
    end
    load = 1'b0; enable = 1'b1; lz_blank = 1'b0;
    run(20);

    // Asynchronous reset in the middle of a drive slot with a load pending.
    run_until(1, BC + 4);
    load_once(16'h5A5A, 4'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_an", 32'(an_n), 32'hF);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dp", 32'(dp_n), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    model_reset();
    @(negedge in_clk);
    reset_n = 1'b1;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
